// File: rtl/vpu_mem_responder_if.sv
// VPU operand/result bus between the VPU control FSM (master) and the
// memory responder (slave): two read lanes, one write lane, status strobes.
interface vpu_mem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13
);
  // Handshake: a request is a single-cycle pulse of rd_*_req / wr_c_req with
  // its address/data held valid in that same cycle. It is taken only while
  // mem_rdy is high; there is no back-pressure once ready. Responses are
  // unhandshaked strobes: mem_read_en qualifies data_a/data_b, and
  // mem_write_en acknowledges a write one cycle after its request.
  logic              rd_a_req;
  logic [ADDR_W-1:0] addr_a;
  logic              rd_b_req;
  logic [ADDR_W-1:0] addr_b;
  logic              wr_c_req;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] data_c;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic              mem_rdy;
  logic              mem_read_en;
  logic              mem_write_en;
  logic              addr_err;

  modport master (
    output rd_a_req, addr_a, rd_b_req, addr_b, wr_c_req, addr_c, data_c,
    input  data_a, data_b, mem_rdy, mem_read_en, mem_write_en, addr_err
  );

  modport slave (
    input  rd_a_req, addr_a, rd_b_req, addr_b, wr_c_req, addr_c, data_c,
    output data_a, data_b, mem_rdy, mem_read_en, mem_write_en, addr_err
  );
endinterface

// File: rtl/vpu_mem_responder.sv
// Memory-side responder: clears a DEPTH-word array after reset, then serves
// two pipelined read lanes and one write lane. Optional macro VPU_MEM_FWD_EN.
module vpu_mem_responder #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 13,
  parameter int DEPTH    = 32,
  parameter int READ_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  vpu_mem_responder_if.slave  m,
  output logic                state_dbg
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  if (READ_LAT < 1 || READ_LAT > 3) begin : g_bad_read_lat
    $error("vpu_mem_responder: READ_LAT must be in 1..3");
  end

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t            state;
  logic [IDX_W-1:0]  clr_cnt;
  logic              rdy_q;
  logic              wr_ack_q;
  logic              err_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [READ_LAT-1:0] pv_a, pv_b;
  logic [DATA_W-1:0]   pw_a [READ_LAT];
  logic [DATA_W-1:0]   pw_b [READ_LAT];

  logic              accept;
  logic              ok_a, ok_b, ok_c;
  logic              take_a, take_b, take_c;
  logic [DATA_W-1:0] word_a, word_b;

  assign accept = rdy_q && !rst;
  // Full-width compare: high address bits must never alias into the array.
  assign ok_a   = m.addr_a < DEPTH_A;
  assign ok_b   = m.addr_b < DEPTH_A;
  assign ok_c   = m.addr_c < DEPTH_A;
  assign take_a = accept && m.rd_a_req;
  assign take_b = accept && m.rd_b_req;
  assign take_c = accept && m.wr_c_req;

  always_comb begin
    word_a = '0;
    word_b = '0;
    if (take_a && ok_a) word_a = mem[m.addr_a[IDX_W-1:0]];
    if (take_b && ok_b) word_b = mem[m.addr_b[IDX_W-1:0]];
`ifdef VPU_MEM_FWD_EN
    if (take_a && take_c && ok_c && (m.addr_a == m.addr_c)) word_a = m.data_c;
    if (take_b && take_c && ok_c && (m.addr_b == m.addr_c)) word_b = m.data_c;
`endif
  end

  // Array has no reset; INIT clears it word by word instead.
  always_ff @(posedge clk) begin
    if (!rst && state == S_INIT) begin
      mem[clr_cnt] <= '0;
    end else if (take_c && ok_c) begin
      mem[m.addr_c[IDX_W-1:0]] <= m.data_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INIT;
      clr_cnt  <= '0;
      rdy_q    <= 1'b0;
      wr_ack_q <= 1'b0;
      err_q    <= 1'b0;
      pv_a     <= '0;
      pv_b     <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        pw_a[i] <= '0;
        pw_b[i] <= '0;
      end
    end else begin
      case (state)
        S_INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_IDX) begin
            state <= S_READY;
            rdy_q <= 1'b1;
          end
        end
        S_READY: rdy_q <= 1'b1;
        default: state <= S_INIT;
      endcase

      wr_ack_q <= take_c;
      if ((take_a && !ok_a) || (take_b && !ok_b) || (take_c && !ok_c)) begin
        err_q <= 1'b1;
      end

      // Non-requesting lanes carry zero so the outputs idle at zero.
      for (int i = READ_LAT - 1; i > 0; i--) begin
        pv_a[i] <= pv_a[i-1];
        pv_b[i] <= pv_b[i-1];
        pw_a[i] <= pw_a[i-1];
        pw_b[i] <= pw_b[i-1];
      end
      pv_a[0] <= take_a;
      pv_b[0] <= take_b;
      pw_a[0] <= word_a;
      pw_b[0] <= word_b;
    end
  end

  assign m.data_a       = pw_a[READ_LAT-1];
  assign m.data_b       = pw_b[READ_LAT-1];
  assign m.mem_read_en  = pv_a[READ_LAT-1] | pv_b[READ_LAT-1];
  assign m.mem_rdy      = rdy_q;
  assign m.mem_write_en = wr_ack_q;
  assign m.addr_err     = err_q;
  assign state_dbg      = (state == S_READY);
endmodule

// File: tb/tb_vpu_mem_responder.sv
// Directed bench for vpu_mem_responder: a queue-based memory model checks all
// outputs every cycle, and directed vectors pin literal expected values.
module tb_vpu_mem_responder;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 13;
  localparam int DEPTH    = 32;
  localparam int READ_LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic state_dbg;

  always #5 clk = ~clk;

  vpu_mem_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  vpu_mem_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(READ_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .m(bus.slave),
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model / scoreboard ----------------
  typedef struct {
    int                due;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } rd_t;

  rd_t               exp_q[$];
  logic [DATA_W-1:0] model_mem [DEPTH];
  int                cyc = 0;
  int                clr_seen = 0;
  bit                started = 0;
  bit                exp_wr = 0;
  bit                exp_err = 0;
  int                ia, ib, ic;
  logic [DATA_W-1:0] ra, rb;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      started  = 1;
      clr_seen = 0;
      exp_wr   = 0;
      exp_err  = 0;
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end else if (clr_seen < DEPTH) begin
      clr_seen++;
      exp_wr = 0;
    end else begin
      ia = int'(bus.addr_a);
      ib = int'(bus.addr_b);
      ic = int'(bus.addr_c);
      ra = '0;
      rb = '0;
      if (bus.rd_a_req && ia < DEPTH) ra = model_mem[ia];
      if (bus.rd_b_req && ib < DEPTH) rb = model_mem[ib];
`ifdef VPU_MEM_FWD_EN
      if (bus.wr_c_req && ic < DEPTH && bus.rd_a_req && ia == ic) ra = bus.data_c;
      if (bus.wr_c_req && ic < DEPTH && bus.rd_b_req && ib == ic) rb = bus.data_c;
`endif
      if (bus.rd_a_req || bus.rd_b_req) exp_q.push_back('{cyc + READ_LAT - 1, ra, rb});
      if (bus.wr_c_req && ic < DEPTH) model_mem[ic] = bus.data_c;
      exp_wr = bus.wr_c_req;
      if ((bus.rd_a_req && ia >= DEPTH) || (bus.rd_b_req && ib >= DEPTH) ||
          (bus.wr_c_req && ic >= DEPTH)) exp_err = 1;
    end
  end

  bit                en_e;
  logic [DATA_W-1:0] a_e, b_e;

  initial forever begin
    @(negedge clk);
    if (started) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
      en_e = 0;
      a_e  = '0;
      b_e  = '0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        en_e = 1;
        a_e  = exp_q[0].a;
        b_e  = exp_q[0].b;
        void'(exp_q.pop_front());
      end
      chk("sb_mem_rdy",      bus.mem_rdy,      clr_seen >= DEPTH);
      chk("sb_state_dbg",    state_dbg,        clr_seen >= DEPTH);
      chk("sb_mem_read_en",  bus.mem_read_en,  en_e);
      chk("sb_data_a",       bus.data_a,       a_e);
      chk("sb_data_b",       bus.data_b,       b_e);
      chk("sb_mem_write_en", bus.mem_write_en, exp_wr);
      chk("sb_addr_err",     bus.addr_err,     exp_err);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.rd_a_req = 1'b0; bus.addr_a = '0;
    bus.rd_b_req = 1'b0; bus.addr_b = '0;
    bus.wr_c_req = 1'b0; bus.addr_c = '0; bus.data_c = '0;
  endtask

  // One request cycle, then literal checks of the ack and the read result.
  task automatic vec(input bit ra_i, input int aa, input bit rb_i, input int ab,
                     input bit w, input int ac, input logic [DATA_W-1:0] dc,
                     input logic [DATA_W-1:0] ea, input logic [DATA_W-1:0] eb);
    @(negedge clk);
    bus.rd_a_req = ra_i; bus.addr_a = ADDR_W'(aa);
    bus.rd_b_req = rb_i; bus.addr_b = ADDR_W'(ab);
    bus.wr_c_req = w;    bus.addr_c = ADDR_W'(ac); bus.data_c = dc;
    @(negedge clk);
    idle();
    if (w) chk("lit_wr_ack", bus.mem_write_en, 1'b1);
    repeat (READ_LAT - 1) @(negedge clk);
    if (ra_i || rb_i) begin
      chk("lit_rd_en", bus.mem_read_en, 1'b1);
      chk("lit_data_a", bus.data_a, ea);
      chk("lit_data_b", bus.data_b, eb);
    end
    @(negedge clk);
    chk("lit_rd_en_low", bus.mem_read_en, 1'b0);
    chk("lit_data_a_idle", bus.data_a, '0);
    chk("lit_data_b_idle", bus.data_b, '0);
    chk("lit_wr_ack_low", bus.mem_write_en, 1'b0);
  endtask

  // Checks mem_rdy low for DEPTH cycles from the release cycle, then high.
  task automatic release_and_wait_ready();
    @(negedge clk);
    rst = 1'b0;
    chk("lit_init_rdy", bus.mem_rdy, 1'b0);
    chk("lit_init_err", bus.addr_err, 1'b0);
    repeat (DEPTH - 1) begin
      @(negedge clk);
      chk("lit_init_rdy", bus.mem_rdy, 1'b0);
      chk("lit_init_rd_en", bus.mem_read_en, 1'b0);
    end
    @(negedge clk);
    chk("lit_ready", bus.mem_rdy, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    release_and_wait_ready();

    vec(1, 31, 0, 0, 0, 0, '0, 32'h0, 32'h0);
    vec(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 32'h0, 32'h0);
    vec(1, 5, 1, 5, 0, 0, '0, 32'hDEADBEEF, 32'hDEADBEEF);

`ifdef VPU_MEM_FWD_EN
    vec(1, 3, 0, 0, 1, 3, 32'h11, 32'h11, 32'h0);
`else
    vec(1, 3, 0, 0, 1, 3, 32'h11, 32'h0, 32'h0);
`endif
    vec(0, 0, 1, 3, 0, 0, '0, 32'h0, 32'h11);

    // Back-to-back writes keep the ack high every cycle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) chk("lit_wr_stream", bus.mem_write_en, 1'b1);
      bus.wr_c_req = 1'b1; bus.addr_c = ADDR_W'(i); bus.data_c = DATA_W'(10 + i);
    end
    @(negedge clk);
    idle();
    chk("lit_wr_stream", bus.mem_write_en, 1'b1);

    // Four reads in consecutive cycles return without bubbles.
    for (int k = 0; k < 4 + READ_LAT; k++) begin
      @(negedge clk);
      if (k >= READ_LAT) begin
        chk("lit_burst_en", bus.mem_read_en, 1'b1);
        chk("lit_burst_a", bus.data_a, DATA_W'(10 + k - READ_LAT));
      end
      if (k < 4) begin
        bus.rd_a_req = 1'b1; bus.addr_a = ADDR_W'(k);
      end else begin
        idle();
      end
    end

    // Out-of-range accesses: zero data, dropped write, sticky error.
    chk("lit_err_before", bus.addr_err, 1'b0);
    vec(0, 0, 1, 40, 0, 0, '0, 32'h0, 32'h0);
    chk("lit_err_set", bus.addr_err, 1'b1);
    vec(0, 0, 0, 0, 1, 40, 32'h99, 32'h0, 32'h0);
    vec(1, 8, 1, 1, 0, 0, '0, 32'h0, 32'd11);
    chk("lit_err_sticky", bus.addr_err, 1'b1);

    // Reset while a read is in flight: the read never returns.
    @(negedge clk);
    bus.rd_a_req = 1'b1; bus.addr_a = ADDR_W'(5);
    @(negedge clk);
    idle();
    rst = 1'b1;
    release_and_wait_ready();
    vec(1, 5, 1, 0, 0, 0, '0, 32'h0, 32'h0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
